tff_toggle_sequencer: RTL and testbench
=======================================

# tff_toggle_sequencer

Controller that sequences the team's T flip-flop cell. It drives the flop's T input with a programmed number of single-cycle toggle pulses, spaced by a programmable gap. It also tracks the expected Q value and flags any divergence from the flop's actual Q, fed back on `q_in`. It sits between a configuration/test source and one `sr_to_t`-style T flip-flop and owns that flop's T input exclusively.

## Interface
- `CNT_W`, default 8: width of toggle count and toggle counter.
- `GAP_W`, default 4: width of inter-pulse gap setting.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  begin a sequence; sampled only in IDLE.
- `cfg_count`  in  CNT_W  number of toggle pulses, latched on accepted start.
- `cfg_gap`  in  GAP_W  idle cycles between pulses, latched on accepted start.
- `abort`  in  1  terminate a running sequence.
- `q_in`  in  1  Q output of the controlled T flip-flop.
- `t_out`  out  1  T input to the flop; high exactly in PULSE state.
- `busy`  out  1  high in PULSE, GAP, CHECK.
- `done`  out  1  one-cycle pulse on normal completion.
- `toggles_done`  out  CNT_W  pulses issued since last accepted start.
- `mismatch`  out  1  sticky: `q_in` differed from expected Q while busy.

## Operation
- States: IDLE, PULSE, GAP, CHECK, DONE. Outputs are decoded from registered state and counters only; there are no combinational paths from inputs to outputs.
- IDLE, `start` = 1, `cfg_count` != 0:
  - Latch `cfg_count` into `remaining` and `cfg_gap` into `gap_cfg`.
  - Capture `q_exp <= q_in`.
  - Clear `toggles_done` and `mismatch`.
  - Go to PULSE.
- IDLE, `start` = 1, `cfg_count` == 0: clear `toggles_done` and `mismatch`, then go to DONE with no pulse.
- PULSE (`t_out` = 1):
  - At the edge: `remaining--`, `toggles_done++`, `q_exp` toggles.
  - Next state when `remaining` reaches 0: CHECK.
  - Otherwise, when `gap_cfg` == 0: stay in PULSE (back-to-back pulses).
  - Otherwise: go to GAP and load `gap_cnt <= gap_cfg`.
- GAP (`t_out` = 0): `gap_cnt--` each cycle; go to PULSE on the cycle `gap_cnt` == 1.
- CHECK: one settle cycle with `t_out` = 0, then DONE.
- DONE: `done` = 1 for one cycle, `busy` = 0, then IDLE. `start` is ignored in DONE.
- Compare: in every PULSE, GAP and CHECK cycle, if `q_in` != `q_exp`, then `mismatch <= 1`. The flag holds until the next accepted start or reset.
- `abort` = 1 in PULSE, GAP or CHECK:
  - Next state is IDLE; `done` is not pulsed.
  - A PULSE cycle with `abort` still delivers its pulse: `t_out` stays 1 that cycle and the toggle is counted.
  - `toggles_done` and `mismatch` keep their values.
- `abort` in IDLE or DONE has no effect.
- `start` while busy is ignored; the running configuration is unaffected.

## Timing
- Reset (`reset` = 0, asynchronous), effective immediately:
  - State goes to IDLE; `t_out`, `busy`, `done`, `mismatch` = 0; `toggles_done` = 0.
  - Internal counters and `q_exp` = 0.
- Reset mid-sequence: `t_out` drops immediately, with no completion pulse.
- Start edge = cycle 0. The first PULSE occupies cycle 1, and `busy` rises in cycle 1.
- For count N and gap G:
  - Pulses occur at cycles 1 + k·(G+1), for k = 0..N-1.
  - The last pulse is at cycle L = 1 + (N-1)(G+1).
  - CHECK is at L+1, `done` at L+2, and IDLE at L+3. At L+3 a new `start` is accepted.
- `toggles_done` increments at each PULSE edge and reads N from cycle L+1 onward.
- `toggles_done` wraps modulo 2^CNT_W; `remaining` cannot underflow because a count of 0 never enters PULSE.
- The flop and this block share `clk`, so `q_in` reflects a pulse one cycle after its PULSE cycle; the `q_exp` update is aligned the same way.

## Test plan
- Reset: drive `reset` = 0 mid-PULSE -> `t_out`/`busy`/`done`/`mismatch`/`toggles_done` all 0 immediately; after release, state is IDLE and `start` is accepted.
- Back-to-back run: count=3, gap=0, start at cycle 0 -> `t_out` = 1 in cycles 1–3, CHECK in cycle 4, `done` in cycle 5, `toggles_done` = 3, and Q ends inverted vs. start.
- Gapped run: count=2, gap=2 -> `t_out` pattern 1,0,0,1 over cycles 1–4, `done` at cycle 6, `mismatch` = 0.
- Zero count: count=0 -> no `t_out` pulse, `done` in cycle 1, `toggles_done` = 0.
- Abort: count=5, gap=1, assert `abort` in cycle 3 (a PULSE cycle) -> that pulse is issued, IDLE in cycle 4, no `done`, `toggles_done` = 2.
- Fault: hold `q_in` stuck at 0 with count=1 -> `mismatch` = 1 from cycle 3 and still set after `done`; it clears on the next start.

Source files
------------

// File: rtl/tff_toggle_sequencer.sv
// tff_toggle_sequencer: issues a programmed number of single-cycle T pulses
// to an external T flip-flop, spaced by a programmable gap, and tracks the
// expected Q against the flop's fed-back Q (sticky mismatch flag).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; start with count 0 goes straight to DONE
// S_PULSE | t_out high for this cycle; toggle counted at the edge
// S_GAP   | t_out low, counting down the inter-pulse gap
// S_CHECK | one settle cycle after the last pulse
// S_DONE  | done high for one cycle, start ignored
module tff_toggle_sequencer #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             abort,
  input  logic             q_in,
  output logic             t_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] toggles_done,
  output logic             mismatch
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PULSE = 3'd1,
    S_GAP   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [GAP_W-1:0] gap_cfg_q, gap_cfg_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             q_exp_q, q_exp_d;
  logic [CNT_W-1:0] toggles_q, toggles_d;
  logic             mismatch_q, mismatch_d;
  logic             busy_st;

  assign busy_st = (state_q == S_PULSE) || (state_q == S_GAP) || (state_q == S_CHECK);

  // Next-state and datapath decode; abort overrides only the state transition,
  // so a pulse issued in the abort cycle is still counted and tracked.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_cfg_d   = gap_cfg_q;
    gap_cnt_d   = gap_cnt_q;
    q_exp_d     = q_exp_q;
    toggles_d   = toggles_q;
    mismatch_d  = mismatch_q;

    if (busy_st && (q_in != q_exp_q)) begin
      mismatch_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          toggles_d  = '0;
          mismatch_d = 1'b0;
          if (cfg_count != '0) begin
            remaining_d = cfg_count;
            gap_cfg_d   = cfg_gap;
            q_exp_d     = q_in;
            state_d     = S_PULSE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_PULSE: begin
        remaining_d = remaining_q - CNT_W'(1);
        toggles_d   = toggles_q + CNT_W'(1);
        q_exp_d     = ~q_exp_q;
        if (remaining_q == CNT_W'(1)) begin
          state_d = S_CHECK;
        end else if (gap_cfg_q != '0) begin
          gap_cnt_d = gap_cfg_q;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = S_PULSE;
        end
      end
      S_CHECK: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && busy_st) begin
      state_d = S_IDLE;
    end
  end

  // State and counter registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      gap_cfg_q   <= '0;
      gap_cnt_q   <= '0;
      q_exp_q     <= 1'b0;
      toggles_q   <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_cfg_q   <= gap_cfg_d;
      gap_cnt_q   <= gap_cnt_d;
      q_exp_q     <= q_exp_d;
      toggles_q   <= toggles_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign t_out        = (state_q == S_PULSE);
  assign busy         = busy_st;
  assign done         = (state_q == S_DONE);
  assign toggles_done = toggles_q;
  assign mismatch     = mismatch_q;

endmodule

// File: tb/tb_tff_toggle_sequencer.sv
// Bench for tff_toggle_sequencer: table of sequences, per-cycle expectations
// derived from the pulse-timing formulas and queued before each run.
module tb_tff_toggle_sequencer;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] cfg_count;
  logic [GAP_W-1:0] cfg_gap;
  logic             abort;
  logic             q_in;
  logic             t_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] toggles_done;
  logic             mismatch;

  logic q_flop;
  logic stuck;

  int n_checks = 0;
  int n_err    = 0;

  tff_toggle_sequencer #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_count    (cfg_count),
    .cfg_gap      (cfg_gap),
    .abort        (abort),
    .q_in         (q_in),
    .t_out        (t_out),
    .busy         (busy),
    .done         (done),
    .toggles_done (toggles_done),
    .mismatch     (mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural T flip-flop sharing the clock; optional stuck-at-0 Q fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_flop <= 1'b0;
    else if (t_out) q_flop <= ~q_flop;
  end
  assign q_in = stuck ? 1'b0 : q_flop;

  typedef struct {
    int count;
    int gap;
    int abort_cyc;
    int start_cyc;
    bit stuck;
    int exp_done;
    int exp_tog;
    bit exp_mm;
  } vec_t;

  typedef struct {
    bit t;
    bit busy;
    bit done;
    int tog;
    bit mm;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   per, last, ncyc, tog, done_seen;
    bit   mm, q_start, q_end;
    exp_t e, g;
    per  = v.gap + 1;
    last = 1 + (v.count - 1) * per;
    if (v.count == 0)        ncyc = 2;
    else if (v.abort_cyc != 0) ncyc = v.abort_cyc + 2;
    else                     ncyc = last + 3;

    tog = 0;
    mm  = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      e.t = 1'b0; e.busy = 1'b0; e.done = 1'b0;
      if (v.count == 0) begin
        e.done = (c == 1);
      end else if (!(v.abort_cyc != 0 && c > v.abort_cyc)) begin
        e.t    = (c <= last) && (((c - 1) % per) == 0);
        e.busy = (c <= last + 1);
        e.done = (c == last + 2);
      end
      e.tog = tog;
      e.mm  = mm;
      sb.push_back(e);
      if (e.busy && v.stuck && e.tog[0]) mm = 1'b1;
      if (e.t) tog++;
    end

    stuck     = v.stuck;
    cfg_count = CNT_W'(v.count);
    cfg_gap   = GAP_W'(v.gap);
    start     = 1'b1;
    q_start   = q_flop;
    @(posedge clk);
    #1;
    start     = 1'b0;
    cfg_count = 8'd77;
    cfg_gap   = 4'd9;
    done_seen = 0;
    for (int c = 1; c <= ncyc; c++) begin
      abort = (c == v.abort_cyc);
      start = (c == v.start_cyc);
      @(negedge clk);
      if (sb.size() == 0) begin
        check($sformatf("v%0d scoreboard_empty c%0d", idx, c), 1, 0);
      end else begin
        g = sb.pop_front();
        check($sformatf("v%0d t_out c%0d", idx, c), int'(t_out), int'(g.t));
        check($sformatf("v%0d busy c%0d", idx, c), int'(busy), int'(g.busy));
        check($sformatf("v%0d done c%0d", idx, c), int'(done), int'(g.done));
        check($sformatf("v%0d toggles c%0d", idx, c), int'(toggles_done), g.tog % 256);
        check($sformatf("v%0d mismatch c%0d", idx, c), int'(mismatch), int'(g.mm));
      end
      if (done && done_seen == 0) done_seen = c;
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    start = 1'b0;
    q_end = q_flop;
    check($sformatf("v%0d done_cycle", idx), done_seen, v.exp_done);
    check($sformatf("v%0d final_toggles", idx), int'(toggles_done), v.exp_tog);
    check($sformatf("v%0d final_mismatch", idx), int'(mismatch), int'(v.exp_mm));
    if (!v.stuck)
      check($sformatf("v%0d q_parity", idx), int'(q_end), int'(q_start ^ v.exp_tog[0]));
  endtask

  initial begin
    //          count gap abort start stuck done tog mm
    vecs[0] = '{3,  0,  0, 0,  1'b0, 5,  3, 1'b0};
    vecs[1] = '{2,  2,  0, 0,  1'b0, 6,  2, 1'b0};
    vecs[2] = '{0,  0,  0, 0,  1'b0, 1,  0, 1'b0};
    vecs[3] = '{5,  1,  3, 0,  1'b0, 0,  2, 1'b0};
    vecs[4] = '{1,  0,  0, 0,  1'b1, 3,  1, 1'b1};
    vecs[5] = '{4,  3,  0, 2,  1'b0, 15, 4, 1'b0};
    vecs[6] = '{3,  1,  4, 0,  1'b0, 0,  2, 1'b0};
    vecs[7] = '{2,  0,  0, 0,  1'b1, 4,  2, 1'b1};
    vecs[8] = '{1,  5,  2, 0,  1'b0, 0,  1, 1'b0};
    vecs[9] = '{2, 15,  0, 19, 1'b0, 19, 2, 1'b0};

    reset = 1'b0; start = 1'b0; abort = 1'b0; stuck = 1'b0;
    cfg_count = '0; cfg_gap = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset t_out", int'(t_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset toggles", int'(toggles_done), 0);
    check("reset mismatch", int'(mismatch), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i]);
      repeat (2) @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a long back-to-back run.
    stuck     = 1'b0;
    cfg_count = 8'd10;
    cfg_gap   = 4'd0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrun t_out", int'(t_out), 1);
    check("midrun toggles", int'(toggles_done), 2);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst t_out", int'(t_out), 0);
    check("async_rst busy", int'(busy), 0);
    check("async_rst done", int'(done), 0);
    check("async_rst toggles", int'(toggles_done), 0);
    check("async_rst mismatch", int'(mismatch), 0);
    @(posedge clk);
    #1;
    check("held_rst t_out", int'(t_out), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_vec(10, vecs[0]);

    if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
